// File: rtl/testport_write_capture_if.sv
// Bus bundle for the test-port capture stage: the snooped data-memory write bus
// plus the valid/ready result stream handed to the checker.
interface testport_write_capture_if;
  logic [29:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        mem_wen;
  logic        out_valid;
  logic [31:0] out_data;
  logic        out_last;
  logic        out_ready;

  // master = CPU/checker side, slave = capture block
  modport master (
    output mem_addr, mem_wdata, mem_wen, out_ready,
    input  out_valid, out_data, out_last
  );
  modport slave (
    input  mem_addr, mem_wdata, mem_wen, out_ready,
    output out_valid, out_data, out_last
  );
endinterface

// File: rtl/testport_write_capture.sv
// Snoops CPU stores to the test port, frames a begin..end session, byte-swaps
// each word and queues it in a first-word-fall-through FIFO for the checker.
module testport_write_capture #(
  parameter logic [29:0] TEST_PORT    = 30'hFF,
  parameter logic [31:0] BEGIN_SYMBOL = 32'h00000168,
  parameter logic [31:0] END_SYMBOL   = 32'hFFFFFD5D,
  parameter int unsigned DEPTH        = 8
) (
  input  logic                      clk,
  input  logic                      rst,
  testport_write_capture_if.slave   bus,
  output logic                      active,
  output logic                      done,
  output logic                      overflow,
  output logic [7:0]                word_count
);

  localparam int unsigned AW = $clog2(DEPTH);

  typedef enum logic {DET_ARMED, DET_HELD} det_e;
  typedef enum logic [1:0] {S_IDLE, S_STREAM, S_DONE} state_e;

  det_e        det_q, det_d;
  state_e      state_q, state_d;
  logic [AW:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic        overflow_q, overflow_d;
  logic [7:0]  word_count_q, word_count_d;
  logic [32:0] mem_q [DEPTH];

  logic [31:0] swapped;
  logic        hit, wr_event, is_end;
  logic        push, push_ok, pop, empty, full;
  logic [32:0] head;

  always_comb begin
    swapped  = {bus.mem_wdata[7:0], bus.mem_wdata[15:8],
                bus.mem_wdata[23:16], bus.mem_wdata[31:24]};
    hit      = bus.mem_wen && (bus.mem_addr == TEST_PORT);
    // A stalled store keeps wen high; only the first cycle after a wen-low counts.
    wr_event = hit && (det_q == DET_ARMED);
    is_end   = (swapped == END_SYMBOL);
    det_d    = bus.mem_wen ? DET_HELD : DET_ARMED;
  end

  // NOTE: every combinational output gets a default first, so no path infers a latch.
  always_comb begin
    state_d = state_q;
    push    = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (wr_event && (swapped == BEGIN_SYMBOL)) state_d = S_STREAM;
      end
      S_STREAM: begin
        if (wr_event) begin
          push = 1'b1;
          if (is_end) state_d = S_DONE;
        end
      end
      S_DONE:  state_d = S_DONE;
      default: state_d = S_IDLE;
    endcase
  end

  // Extra pointer MSB distinguishes full from empty when the index bits match.
  always_comb begin
    empty        = (wr_ptr_q == rd_ptr_q);
    full         = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                   (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    pop          = !empty && bus.out_ready;
    push_ok      = push && (!full || pop);
    wr_ptr_d     = wr_ptr_q + {{AW{1'b0}}, push_ok};
    rd_ptr_d     = rd_ptr_q + {{AW{1'b0}}, pop};
    overflow_d   = overflow_q || (push && !push_ok);
    word_count_d = (push_ok && (word_count_q != 8'hFF)) ? word_count_q + 8'd1
                                                         : word_count_q;
  end

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      det_q        <= DET_ARMED;
      state_q      <= S_IDLE;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      overflow_q   <= 1'b0;
      word_count_q <= 8'd0;
    end else begin
      det_q        <= det_d;
      state_q      <= state_d;
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      overflow_q   <= overflow_d;
      word_count_q <= word_count_d;
    end
  end

  // NOTE: storage is not reset; the pointers alone define which entries are valid.
  always_ff @(posedge clk) begin
    if (push_ok) mem_q[wr_ptr_q[AW-1:0]] <= {swapped, is_end};
  end

  assign head          = mem_q[rd_ptr_q[AW-1:0]];
  assign bus.out_valid = !empty;
  assign bus.out_data  = empty ? 32'h0 : head[32:1];
  assign bus.out_last  = !empty && head[0];
  assign active        = (state_q == S_STREAM);
  assign done          = (state_q == S_DONE);
  assign overflow      = overflow_q;
  assign word_count    = word_count_q;

endmodule

// File: tb/tb_testport_write_capture.sv
// Directed bench for testport_write_capture: session framing, stall handling,
// FIFO overflow/full push-pop and asynchronous mid-session reset.
module tb_testport_write_capture;

  localparam logic [29:0] TP      = 30'hFF;
  localparam logic [31:0] BEGIN_LE = 32'h68010000;
  localparam logic [31:0] END_LE   = 32'h5DFDFFFF;

  logic       clk = 1'b0;
  logic       rst;
  logic       active, done, overflow;
  logic [7:0] word_count;
  int         errors = 0;
  int         checks = 0;

  testport_write_capture_if bus ();

  testport_write_capture #(.DEPTH(8)) dut (
    .clk        (clk),
    .rst        (rst),
    .bus        (bus),
    .active     (active),
    .done       (done),
    .overflow   (overflow),
    .word_count (word_count)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] actual,
                       input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("FAIL %s: got %h, expected %h", tag, actual, expected);
    end
  endtask

  // Inputs change and outputs are sampled 1 ns after the rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Little-endian image of a small value n: swapped form is 32'h000000nn.
  function automatic logic [31:0] le8(input logic [7:0] n);
    return {n, 24'h000000};
  endfunction

  task automatic do_write(input logic [29:0] addr, input logic [31:0] data, input int hold);
    bus.mem_addr  = addr;
    bus.mem_wdata = data;
    bus.mem_wen   = 1'b1;
    repeat (hold) step();
    bus.mem_wen   = 1'b0;
    step();
  endtask

  task automatic pop_expect(input string tag, input logic [31:0] data, input logic last);
    check({tag, "/valid"}, {31'd0, bus.out_valid}, 32'd1);
    check({tag, "/data"},  bus.out_data, data);
    check({tag, "/last"},  {31'd0, bus.out_last}, {31'd0, last});
    bus.out_ready = 1'b1;
    step();
    bus.out_ready = 1'b0;
  endtask

  task automatic check_reset_state(input string tag);
    check({tag, "/valid"}, {31'd0, bus.out_valid}, 32'd0);
    check({tag, "/data"},  bus.out_data, 32'd0);
    check({tag, "/last"},  {31'd0, bus.out_last}, 32'd0);
    check({tag, "/active"}, {31'd0, active}, 32'd0);
    check({tag, "/done"},   {31'd0, done}, 32'd0);
    check({tag, "/ovf"},    {31'd0, overflow}, 32'd0);
    check({tag, "/wc"},     {24'd0, word_count}, 32'd0);
  endtask

  task automatic do_reset();
    rst = 1'b0;
    step();
    rst = 1'b1;
    step();
  endtask

  initial begin
    rst           = 1'b0;
    bus.mem_addr  = '0;
    bus.mem_wdata = '0;
    bus.mem_wen   = 1'b0;
    bus.out_ready = 1'b0;
    repeat (2) step();
    check_reset_state("rst0");
    rst = 1'b1;
    step();

    // Basic session: begin, one data word, end; later events ignored in DONE.
    do_write(TP, BEGIN_LE, 1);
    check("s1/active", {31'd0, active}, 32'd1);
    check("s1/begin_not_pushed", {31'd0, bus.out_valid}, 32'd0);
    do_write(TP, le8(8'd1), 1);
    do_write(TP, END_LE, 1);
    check("s1/done", {31'd0, done}, 32'd1);
    check("s1/active_off", {31'd0, active}, 32'd0);
    check("s1/wc", {24'd0, word_count}, 32'd2);
    pop_expect("s1/w0", 32'h00000001, 1'b0);
    pop_expect("s1/w1", 32'hFFFFFD5D, 1'b1);
    check("s1/empty", {31'd0, bus.out_valid}, 32'd0);
    do_write(TP, le8(8'd7), 1);
    check("s1/done_ignores", {31'd0, bus.out_valid}, 32'd0);

    // Stall-held write, single wen-low separation, other address, no re-arm.
    do_reset();
    do_write(TP, le8(8'd9), 1);
    check("s2/idle_ignores", {31'd0, bus.out_valid}, 32'd0);
    do_write(TP, BEGIN_LE, 1);
    do_write(TP, le8(8'd5), 4);
    check("s2/held_wc", {24'd0, word_count}, 32'd1);
    pop_expect("s2/held", 32'h00000005, 1'b0);
    check("s2/held_once", {31'd0, bus.out_valid}, 32'd0);
    do_write(TP, le8(8'd6), 1);
    do_write(TP, le8(8'd7), 1);
    check("s2/b2b_wc", {24'd0, word_count}, 32'd3);
    pop_expect("s2/b2b0", 32'h00000006, 1'b0);
    pop_expect("s2/b2b1", 32'h00000007, 1'b0);
    do_write(30'h10, le8(8'd9), 1);
    check("s2/other_addr", {31'd0, bus.out_valid}, 32'd0);
    bus.mem_addr  = 30'h10;
    bus.mem_wdata = le8(8'd9);
    bus.mem_wen   = 1'b1;
    step();
    step();
    bus.mem_addr  = TP;
    step();
    bus.mem_wen   = 1'b0;
    step();
    check("s2/no_rearm_valid", {31'd0, bus.out_valid}, 32'd0);
    check("s2/no_rearm_wc", {24'd0, word_count}, 32'd3);
    check("s2/ovf_clear", {31'd0, overflow}, 32'd0);
    check("s2/begin_as_data_pre", {31'd0, active}, 32'd1);
    do_write(TP, BEGIN_LE, 1);
    pop_expect("s2/begin_as_data", 32'h00000168, 1'b0);

    // Overflow: 10 writes into an 8-deep FIFO with no consumer.
    do_reset();
    do_write(TP, BEGIN_LE, 1);
    for (int i = 1; i <= 10; i++) do_write(TP, le8(8'(i)), 1);
    check("s3/ovf", {31'd0, overflow}, 32'd1);
    check("s3/wc", {24'd0, word_count}, 32'd8);
    for (int i = 1; i <= 8; i++) pop_expect($sformatf("s3/drain%0d", i), 32'(i), 1'b0);
    check("s3/drained", {31'd0, bus.out_valid}, 32'd0);

    // Full FIFO with simultaneous push and pop: push succeeds at the tail.
    for (int i = 21; i <= 28; i++) do_write(TP, le8(8'(i)), 1);
    check("s4/wc_full", {24'd0, word_count}, 32'd16);
    bus.mem_addr  = TP;
    bus.mem_wdata = le8(8'd29);
    bus.mem_wen   = 1'b1;
    bus.out_ready = 1'b1;
    step();
    bus.mem_wen   = 1'b0;
    bus.out_ready = 1'b0;
    step();
    check("s4/wc_pp", {24'd0, word_count}, 32'd17);
    for (int i = 22; i <= 29; i++) pop_expect($sformatf("s4/drain%0d", i), 32'(i), 1'b0);
    check("s4/drained", {31'd0, bus.out_valid}, 32'd0);
    check("s4/ovf_sticky", {31'd0, overflow}, 32'd1);

    // Asynchronous reset with 3 words queued, then behaviour after release.
    for (int i = 31; i <= 33; i++) do_write(TP, le8(8'(i)), 1);
    check("s5/queued", {24'd0, word_count}, 32'd20);
    rst = 1'b0;
    #2;
    check_reset_state("s5/async");
    step();
    rst = 1'b1;
    step();
    do_write(TP, le8(8'd4), 1);
    check("s5/no_begin_valid", {31'd0, bus.out_valid}, 32'd0);
    check("s5/no_begin_wc", {24'd0, word_count}, 32'd0);
    check("s5/no_begin_active", {31'd0, active}, 32'd0);

    // wen already high at reset release is seen as an event on the first edge.
    rst           = 1'b0;
    bus.mem_addr  = TP;
    bus.mem_wdata = BEGIN_LE;
    bus.mem_wen   = 1'b1;
    #2;
    rst = 1'b1;
    step();
    bus.mem_wen = 1'b0;
    check("s6/armed_release", {31'd0, active}, 32'd1);
    step();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
